// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared constants, types and helpers for the pipelined adder.
//   DEF_WIDTH / DEF_CHUNK : default operand width and bits added per stage
//   op_e                  : operation select encoding (add / subtract)
//   calc_stages()         : WIDTH/CHUNK, or 0 when CHUNK does not divide WIDTH
package pipe_adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // A zero result marks an illegal configuration; the top refuses to elaborate it.
  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned chunk);
    if (chunk == 0 || width == 0 || (width % chunk) != 0) return 0;
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// pipe_add_stage: one CHUNK-bit ripple segment of the pipelined adder.
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : pipeline advance; all registers hold when low
//   in_valid      : valid bit travelling with this segment's operands
//   a, b, cin     : chunk operands (b already inverted for subtract) and carry-in
//   out_valid     : registered valid
//   s, cout       : registered chunk sum and carry out of the chunk MSB
//   cmsb          : registered carry into the chunk MSB (for signed overflow)
module pipe_add_stage
  import pipe_adder_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK-1:0] s_n;
  logic [CHUNK:0]   c;

  always_comb begin
    s_n  = '0;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s_n[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      cmsb      <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      s         <= s_n;
      cout      <= c[CHUNK];
      cmsb      <= c[CHUNK-1];
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit add/subtract, one CHUNK-bit ripple per stage,
// latency STAGES = WIDTH/CHUNK cycles, throughput one per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake
//   a, b, cin, sub       : operands; sub=0 a+b+cin, sub=1 a-b-cin
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : result mod 2^WIDTH, carry / not-borrow, signed overflow
// Build option: define PIPE_ADDER_SAT_EN to saturate sum on signed overflow.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

  if (STAGES == 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  op_e              op;
  logic [WIDTH-1:0] bx;
  logic             c0;
  logic             adv;
  logic [WIDTH-1:0] raw;

  // Triangular use of the square arrays: a_dly/b_dly[s][c] holds operand chunk c
  // (c > s) after s+1 register stages; lo[s][c] holds finished sum chunk c (c < s)
  // aligned with stage s. Unused corners are never written or read.
  logic [CHUNK-1:0] a_dly [STAGES][STAGES];
  logic [CHUNK-1:0] b_dly [STAGES][STAGES];
  logic [CHUNK-1:0] lo    [STAGES][STAGES];

  logic [CHUNK-1:0] st_a    [STAGES];
  logic [CHUNK-1:0] st_b    [STAGES];
  logic [CHUNK-1:0] st_s    [STAGES];
  logic             st_cin  [STAGES];
  logic             st_vin  [STAGES];
  logic             st_v    [STAGES];
  logic             st_cout [STAGES];
  logic             st_cmsb [STAGES];

  assign op = op_e'(sub);

  // Subtract as a + ~b + ~cin so the final carry is already the not-borrow.
  always_comb begin
    bx = (op == OP_SUB) ? ~b : b;
    c0 = (op == OP_SUB) ? ~cin : cin;
  end

  assign out_valid = st_v[STAGES-1];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign st_a[k]   = a[CHUNK-1:0];
      assign st_b[k]   = bx[CHUNK-1:0];
      assign st_cin[k] = c0;
      assign st_vin[k] = in_valid;
    end else begin : g_next
      assign st_a[k]   = a_dly[k-1][k];
      assign st_b[k]   = b_dly[k-1][k];
      assign st_cin[k] = st_cout[k-1];
      assign st_vin[k] = st_v[k-1];
    end

    pipe_add_stage #(.CHUNK(CHUNK)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .in_valid  (st_vin[k]),
      .a         (st_a[k]),
      .b         (st_b[k]),
      .cin       (st_cin[k]),
      .out_valid (st_v[k]),
      .s         (st_s[k]),
      .cout      (st_cout[k]),
      .cmsb      (st_cmsb[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        for (int unsigned c = 0; c < STAGES; c++) begin
          a_dly[s][c] <= '0;
          b_dly[s][c] <= '0;
          lo[s][c]    <= '0;
        end
      end
    end else if (adv) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        for (int unsigned c = 0; c < STAGES; c++) begin
          if (c > s) begin
            if (s == 0) begin
              a_dly[s][c] <= a[c*CHUNK +: CHUNK];
              b_dly[s][c] <= bx[c*CHUNK +: CHUNK];
            end else begin
              a_dly[s][c] <= a_dly[s-1][c];
              b_dly[s][c] <= b_dly[s-1][c];
            end
          end
          if (c < s) begin
            if (c == s - 1) lo[s][c] <= st_s[c];
            else            lo[s][c] <= lo[s-1][c];
          end
        end
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int unsigned c = 0; c + 1 < STAGES; c++) begin
      raw[c*CHUNK +: CHUNK] = lo[STAGES-1][c];
    end
    raw[(STAGES-1)*CHUNK +: CHUNK] = st_s[STAGES-1];
  end

  assign cout = st_cout[STAGES-1];
  assign ovf  = st_cout[STAGES-1] ^ st_cmsb[STAGES-1];

`ifdef PIPE_ADDER_SAT_EN
  // On overflow the wrapped MSB is the inverse of the true sign.
  assign sum = ovf ? {~raw[WIDTH-1], {(WIDTH-1){raw[WIDTH-1]}}} : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the team's 8-bit ripple adder.
- Splits a WIDTH-bit add/subtract into CHUNK-bit ripple segments, one segment per pipeline stage; carry is registered between stages.
- Valid/ready handshake on both sides; drop-in arithmetic unit for datapaths that need wide adds at full clock rate.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 8, bits added per stage; derived localparam STAGES = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A, unsigned/two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a-b-cin.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out (add); not-borrow (sub: 1 when a >= b+cin unsigned).
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Sub mode: internally b' = ~b, c0 = ~cin; add mode: b' = b, c0 = cin. Stage k adds a[k*CHUNK+:CHUNK] + b'[same] + carry_k.
- Operand skew: upper chunks of a/b' are delay-registered so chunk k reaches its adder at stage k; completed lower chunks are carried forward in registers. No combinational path spans more than one CHUNK-bit ripple.
- Latency: exactly STAGES cycles from accepted input (in_valid & in_ready) to out_valid, absent stalls. Throughput 1 per cycle.
- Global advance: adv = out_ready | ~out_valid. in_ready = adv. All stage registers and per-stage valid bits update only when adv=1; when adv=0 the whole pipeline holds (bubbles are not squeezed out).
- Transfer at output when out_valid & out_ready; sum/cout/ovf stable while out_valid=1 and out_ready=0.
- ovf = carry into MSB XOR carry out of MSB (final stage).
- cout = carry out of the final stage (already the not-borrow in sub mode due to inversion).
- Reset (asserted anytime, incl. mid-stream): all valid bits 0, out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 once rst_n released; in-flight operations discarded.
- in_valid=0 with adv=1 injects a bubble; data regs may load don't-care but valid must be 0.
- STAGES=1 (CHUNK=WIDTH) is legal: single registered ripple adder, latency 1.

Optional Feature:
- Macro PIPE_ADDER_SAT_EN.
- Defined: when ovf=1, sum is replaced by signed saturation: 0 + 1s (max positive) if the true result's sign is positive (a[MSB]=0 in add, a[MSB]=0 in sub), else 1 + 0s (min negative); ovf still reported; cout unchanged.
- Not defined: sum is the wrap-around result; no extra logic.

Decomposition:
- Shared package: pipe_adder_pkg with default WIDTH/CHUNK constants and a function computing STAGES with divisibility check.
- One sub-module: pipe_add_stage (CHUNK-bit full ripple add, carry in/out, registered with enable, valid passthrough), instantiated STAGES times via generate.

Test Plan (WIDTH=32, CHUNK=8, out_ready=1 unless stated):
- a=0xFFFF_FFFF, b=1, cin=0, sub=0 -> after 4 cycles sum=0, cout=1, ovf=0.
- a=0x7FFF_FFFF, b=1, sub=0 -> sum=0x8000_0000, ovf=1, cout=0; with PIPE_ADDER_SAT_EN sum=0x7FFF_FFFF.
- a=5, b=7, cin=0, sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0; a=7, b=5, cin=1, sub=1 -> sum=1, cout=1.
- Back-to-back 10 random vectors, in_valid=1 every cycle -> 10 results in order, one per cycle, first 4 cycles after first accept.
- Hold out_ready=0 for 3 cycles with pipeline full -> in_ready=0, sum stable, no loss or duplication after release.
- Assert rst_n=0 with 3 ops in flight -> out_valid=0, sum=0 immediately (async); no stale result after release.
